// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - 8-channel ADC scan sequencer with channel re-tagging, decimation and 2-entry output FIFO
// Optional build macro ADC_SEQ_HOLD_EN adds an 8x12 latest-value register file read via rd_ch/rd_data.
module adc_scan_sequencer #(
  parameter int DECIM_W = 8,
  parameter int FIFO_D  = 2
) (
  input  logic               clk,
  input  logic               Resetn,
  input  logic               enable,
  input  logic [7:0]         ch_mask,
  input  logic [DECIM_W-1:0] decim,
  input  logic               frame_done,
  input  logic [11:0]        adc_data,
  output logic [2:0]         adc_add,
  output logic               out_valid,
  output logic [11:0]        out_data,
  output logic [2:0]         out_ch,
  input  logic               out_ready,
  output logic               overflow,
  output logic [7:0]         drop_cnt,
  input  logic               ovf_clr,
`ifdef ADC_SEQ_HOLD_EN
  input  logic [2:0]         rd_ch,
  output logic [11:0]        rd_data,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t             state, state_n;
  logic [7:0]         shadow;
  logic [2:0]         prev_ch;
  logic               prev_vld;
  logic [DECIM_W-1:0] rcnt;

  logic               start, step, drain, push, pop, drop, full;
  logic               sample_ok;
  logic [3:0]         nxt;
  logic               wrap;

  logic [14:0]        e0, e1;
  logic [1:0]         fifo_cnt;

  // Lowest set bit of a mask; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above a.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] a);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (3'(i) > a)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // The sample returned this frame belongs to the address driven one frame earlier.
  assign sample_ok = prev_vld && shadow[prev_ch];
  assign nxt       = next_above(shadow, adc_add);
  assign wrap      = !nxt[3];
  assign busy      = (state != IDLE);

  assign full      = (fifo_cnt == 2'(FIFO_D));
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign drop      = push && full && !pop;
  assign out_ch    = e0[14:12];
  assign out_data  = e0[11:0];

  // State register.
  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-frame action decode; every action is qualified by frame_done.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    drain   = 1'b0;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_done && enable) begin
          state_n = SCAN;
          start   = 1'b1;
        end
      end
      SCAN: begin
        if (frame_done) begin
          step = 1'b1;
          push = sample_ok && (rcnt == '0);
          if (!enable) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_done) begin
          drain   = 1'b1;
          push    = sample_ok && (rcnt == '0);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Address sequencing, channel-tag pipeline, mask shadowing and round counter.
  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      adc_add  <= '0;
      shadow   <= '0;
      prev_ch  <= '0;
      prev_vld <= 1'b0;
      rcnt     <= '0;
    end else if (start) begin
      shadow   <= ch_mask;
      adc_add  <= lowest_set(ch_mask);
      prev_vld <= 1'b0;
      rcnt     <= '0;
    end else if (step) begin
      prev_ch  <= adc_add;
      prev_vld <= 1'b1;
      if (wrap) begin
        // Round end: new mask is picked up only here, so mid-round edits wait.
        shadow  <= ch_mask;
        adc_add <= lowest_set(ch_mask);
        rcnt    <= (rcnt == decim) ? '0 : rcnt + DECIM_W'(1);
      end else begin
        adc_add <= nxt[2:0];
      end
    end else if (drain) begin
      prev_vld <= 1'b0;
    end
  end

  // Two-entry fall-through FIFO; e0 is always the head.
  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      e0       <= '0;
      e1       <= '0;
      fifo_cnt <= '0;
    end else if (push && pop) begin
      if (fifo_cnt == 2'd2) begin
        e0 <= e1;
        e1 <= {prev_ch, adc_data};
      end else begin
        e0 <= {prev_ch, adc_data};
      end
    end else if (push) begin
      if (fifo_cnt == 2'd0) begin
        e0       <= {prev_ch, adc_data};
        fifo_cnt <= 2'd1;
      end else if (fifo_cnt == 2'd1) begin
        e1       <= {prev_ch, adc_data};
        fifo_cnt <= 2'd2;
      end
    end else if (pop) begin
      e0       <= e1;
      fifo_cnt <= fifo_cnt - 2'd1;
    end
  end

  // Sticky overflow and saturating drop counter; a clear coincident with a drop still records that drop.
  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      overflow <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef ADC_SEQ_HOLD_EN
  logic [11:0] hold_mem [8];

  // Latest value per channel, independent of decimation and FIFO occupancy.
  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      for (int i = 0; i < 8; i++) hold_mem[i] <= '0;
    end else if ((step || drain) && sample_ok) begin
      hold_mem[prev_ch] <= adc_data;
    end
  end

  assign rd_data = hold_mem[rd_ch];
`endif

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        Resetn;
  logic        enable;
  logic [7:0]  ch_mask;
  logic [7:0]  decim;
  logic        frame_done;
  logic [11:0] adc_data;
  logic [2:0]  adc_add;
  logic        out_valid;
  logic [11:0] out_data;
  logic [2:0]  out_ch;
  logic        out_ready;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        ovf_clr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  adc_scan_sequencer #(.DECIM_W(8), .FIFO_D(2)) dut (
    .clk(clk), .Resetn(Resetn), .enable(enable), .ch_mask(ch_mask), .decim(decim),
    .frame_done(frame_done), .adc_data(adc_data), .adc_add(adc_add),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
    .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: a single frame_done cycle, returning at the following negedge.
  task automatic fd(input logic [11:0] d);
    @(negedge clk);
    frame_done = 1'b1;
    adc_data   = d;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  logic [17:0] t3_v;
  int          t3_ch [18];

  initial begin
    Resetn = 1'b1; enable = 1'b0; ch_mask = '0; decim = '0; frame_done = 1'b0;
    adc_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    t3_v  = 18'h1E01C;
    t3_ch = '{0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 2, 0};
    @(negedge clk); @(negedge clk);
    chk("rst_add", 32'(adc_add), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    Resetn = 1'b0;

    // Two-channel mask, no decimation, plus drain on disable
    ch_mask = 8'h05; out_ready = 1'b1; enable = 1'b1;
    fd(0);   chk("t1_add0", 32'(adc_add), 0); chk("t1_busy", 32'(busy), 1); chk("t1_v0", 32'(out_valid), 0);
    fd(900); chk("t1_add1", 32'(adc_add), 2); chk("t1_v1", 32'(out_valid), 0);
    fd(0);   chk("t1_v2", 32'(out_valid), 1); chk("t1_ch2", 32'(out_ch), 0); chk("t1_d2", 32'(out_data), 0);
             chk("t1_add2", 32'(adc_add), 0);
    fd(200); chk("t1_ch3", 32'(out_ch), 2); chk("t1_d3", 32'(out_data), 200); chk("t1_add3", 32'(adc_add), 2);
    fd(0);   chk("t1_ch4", 32'(out_ch), 0); chk("t1_add4", 32'(adc_add), 0);
    enable = 1'b0;
    fd(200); chk("t6_ch_a", 32'(out_ch), 2); chk("t6_d_a", 32'(out_data), 200); chk("t6_busy_a", 32'(busy), 1);
    fd(7);   chk("t6_ch_b", 32'(out_ch), 0); chk("t6_d_b", 32'(out_data), 7); chk("t6_busy_b", 32'(busy), 0);
    fd(55);  chk("t6_v_c", 32'(out_valid), 0);

    // Single channel 7
    ch_mask = 8'h80; enable = 1'b1;
    fd(0);   chk("t2_add0", 32'(adc_add), 7);
    fd(1);   chk("t2_v1", 32'(out_valid), 0); chk("t2_add1", 32'(adc_add), 7);
    fd(700); chk("t2_ch2", 32'(out_ch), 7); chk("t2_d2", 32'(out_data), 700);
    fd(701); chk("t2_d3", 32'(out_data), 701); chk("t2_add3", 32'(adc_add), 7);
    enable = 1'b0;
    fd(702); chk("t2_d4", 32'(out_data), 702);
    fd(703); chk("t2_d5", 32'(out_data), 703); chk("t2_busy", 32'(busy), 0);
    fd(0);   chk("t2_v6", 32'(out_valid), 0);

    // Four channels, decim=2: only rounds with counter 0 are emitted
    ch_mask = 8'h0F; decim = 8'd2; enable = 1'b1;
    fd(0);
    for (int i = 1; i <= 17; i++) begin
      fd(12'(i));
      chk($sformatf("t3_v%0d", i), 32'(out_valid), 32'(t3_v[i]));
      if (t3_v[i]) begin
        chk($sformatf("t3_ch%0d", i), 32'(out_ch), 32'(t3_ch[i]));
        chk($sformatf("t3_d%0d", i), 32'(out_data), 32'(i));
      end
    end
    enable = 1'b0;
    fd(0); fd(0);
    chk("t3_busy", 32'(busy), 0); chk("t3_v_end", 32'(out_valid), 0);

    // Back-pressure, overflow, clear, push+pop when full, saturation
    ch_mask = 8'h01; decim = 8'd0; out_ready = 1'b0; enable = 1'b1;
    fd(0); fd(0);
    for (int i = 11; i <= 15; i++) fd(12'(i));
    chk("t4_ovf", 32'(overflow), 1); chk("t4_drop", 32'(drop_cnt), 3);
    chk("t4_v", 32'(out_valid), 1); chk("t4_head", 32'(out_data), 11); chk("t4_ch", 32'(out_ch), 0);
    @(negedge clk); ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    chk("t4_clr_ovf", 32'(overflow), 0); chk("t4_clr_drop", 32'(drop_cnt), 0); chk("t4_hold", 32'(out_data), 11);
    @(negedge clk); frame_done = 1'b1; adc_data = 12'd16; ovf_clr = 1'b1;
    @(negedge clk); frame_done = 1'b0; ovf_clr = 1'b0;
    chk("t4_coinc_ovf", 32'(overflow), 1); chk("t4_coinc_drop", 32'(drop_cnt), 1);
    @(negedge clk); frame_done = 1'b1; adc_data = 12'd17; out_ready = 1'b1;
    @(negedge clk); frame_done = 1'b0; out_ready = 1'b0;
    chk("t4_pp_drop", 32'(drop_cnt), 1); chk("t4_pp_head", 32'(out_data), 12);
    for (int i = 0; i < 260; i++) fd(12'd99);
    chk("t4_sat", 32'(drop_cnt), 255); chk("t4_sat_ovf", 32'(overflow), 1);

    // Asynchronous reset mid-frame
    @(negedge clk); #2 Resetn = 1'b1; #1;
    chk("t6r_add", 32'(adc_add), 0); chk("t6r_valid", 32'(out_valid), 0);
    chk("t6r_data", 32'(out_data), 0); chk("t6r_ovf", 32'(overflow), 0);
    chk("t6r_drop", 32'(drop_cnt), 0); chk("t6r_busy", 32'(busy), 0);
    @(negedge clk); Resetn = 1'b0;

    // Mask change mid-round
    ch_mask = 8'h03; out_ready = 1'b1; enable = 1'b1;
    fd(0);   chk("t5_add0", 32'(adc_add), 0);
    fd(0);   chk("t5_add1", 32'(adc_add), 1); chk("t5_v1", 32'(out_valid), 0);
    ch_mask = 8'h30;
    fd(5);   chk("t5_ch2", 32'(out_ch), 0); chk("t5_d2", 32'(out_data), 5); chk("t5_add2", 32'(adc_add), 4);
    fd(100); chk("t5_v3", 32'(out_valid), 0); chk("t5_add3", 32'(adc_add), 5);
    fd(400); chk("t5_ch4", 32'(out_ch), 4); chk("t5_d4", 32'(out_data), 400); chk("t5_add4", 32'(adc_add), 4);
    fd(500); chk("t5_ch5", 32'(out_ch), 5); chk("t5_d5", 32'(out_data), 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
